// File: rtl/chi_txreq_sched.sv
// chi_txreq_sched: two-source CHI TXREQ arbiter with L-credit, TxnID and link-state tracking
module chi_txreq_sched #(
    parameter int MAX_CRD = 15,
    parameter int NUM_TXN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               link_en,
    input  logic [1:0]         req_valid,
    input  logic [307:0]       req_flit,
    output logic [1:0]         req_ready,
    output logic               TX_REQFLITPEND,
    output logic               TX_REQFLITV,
    output logic [153:0]       TX_REQFLIT,
    input  logic               TX_REQLCRDV,
    input  logic               RX_RSPFLITV,
    input  logic [72:0]        RX_RSPFLIT,
    output logic [3:0]         crd_cnt,
    output logic [NUM_TXN-1:0] txn_busy,
    output logic [1:0]         link_state,
    output logic               err_crd_ovf,
    output logic               err_unexp_comp
);
    localparam int IW = $clog2(NUM_TXN);
    localparam logic [1:0] STOP = 2'd0, RUN = 2'd1, RET = 2'd2;
    logic [1:0] state, state_nxt;
    logic ptr, pick, can_grant, grant, ret_fire, consume, comp_v, comp_hit, comp_bad;
    logic [IW-1:0] free_id;
    logic [153:0] sel_flit;
    logic [11:0] rsp_id;
    logic [NUM_TXN-1:0] set_mask, clr_mask;
    logic unused_rsp;
    assign unused_rsp = ^{RX_RSPFLIT[72:43], RX_RSPFLIT[25:0]};
    always_ff @(posedge clk)
        if (rst) state <= STOP;
        else state <= state_nxt;
    always_comb begin
        state_nxt = (state == STOP) ? (link_en ? RUN : STOP) :
                    (state == RUN)  ? (link_en ? RUN : RET) :
                    (state == RET)  ? ((crd_cnt == 4'd0) ? STOP : RET) : STOP;
    end
    always_comb begin
        link_state = state;
        ret_fire   = (state == RET) && (crd_cnt != 4'd0);
        can_grant  = !rst && (state == RUN) && link_en && (crd_cnt != 4'd0) && !(&txn_busy);
    end
    always_comb begin
        pick      = (&req_valid) ? ptr : req_valid[1];
        req_ready = (can_grant && |req_valid) ? (pick ? 2'b10 : 2'b01) : 2'b00;
        grant     = |req_ready;
        consume   = grant || ret_fire;
        sel_flit  = pick ? req_flit[307:154] : req_flit[153:0];
        free_id   = '0;
        for (int i = NUM_TXN - 1; i >= 0; i--)
            if (!txn_busy[i]) free_id = IW'(i);
        rsp_id    = RX_RSPFLIT[37:26];
        comp_v    = RX_RSPFLITV && (RX_RSPFLIT[42:38] == 5'h04);
        comp_hit  = comp_v && (rsp_id < 12'(NUM_TXN)) && txn_busy[rsp_id[IW-1:0]];
        comp_bad  = comp_v && !comp_hit;
        set_mask  = grant ? ({{(NUM_TXN-1){1'b0}}, 1'b1} << free_id) : '0;
        clr_mask  = comp_hit ? ({{(NUM_TXN-1){1'b0}}, 1'b1} << rsp_id[IW-1:0]) : '0;
    end
    // A credit arriving at MAX_CRD with nothing consumed is dropped and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= 1'b0;
            crd_cnt        <= '0;
            txn_busy       <= '0;
            err_crd_ovf    <= 1'b0;
            err_unexp_comp <= 1'b0;
            TX_REQFLITV    <= 1'b0;
            TX_REQFLIT     <= '0;
            TX_REQFLITPEND <= 1'b0;
        end else begin
            ptr            <= grant ? ~pick : ptr;
            crd_cnt        <= (TX_REQLCRDV && !consume) ? ((crd_cnt == 4'(MAX_CRD)) ? crd_cnt : crd_cnt + 4'd1) :
                              (!TX_REQLCRDV && consume) ? crd_cnt - 4'd1 : crd_cnt;
            err_crd_ovf    <= err_crd_ovf || (TX_REQLCRDV && !consume && crd_cnt == 4'(MAX_CRD));
            err_unexp_comp <= err_unexp_comp || comp_bad;
            txn_busy       <= (txn_busy & ~clr_mask) | set_mask;
            TX_REQFLITV    <= consume;
            TX_REQFLIT     <= grant ? {sel_flit[153:38], 12'(free_id), sel_flit[25:0]} : ret_fire ? '0 : TX_REQFLIT;
            TX_REQFLITPEND <= (|req_valid) || (state_nxt == RET);
        end
    end
endmodule

// File: doc/chi_txreq_sched.md
CHI_TXREQ_SCHED -- requirements
Module: chi_txreq_sched

Interface
REQ-001 SHALL have parameters, one per line:
  MAX_CRD, 15, maximum L-credits held (1..15).
  NUM_TXN, 8, outstanding TxnIDs (power of 2, 2..16).
REQ-002 SHALL have ports, one per line (name direction width meaning):
  clk  in  1  single clock, all logic on posedge.
  rst  in  1  synchronous, active-high reset.
  link_en  in  1  1 = link run requested, 0 = deactivate.
  req_valid  in  2  per-source request valid.
  req_flit  in  308  source i flit at [154*i+153:154*i].
  req_ready  out  2  per-source grant, combinational, one-hot or zero.
  TX_REQFLITPEND  out  1  registered: any req_valid in previous cycle, or state RETURN.
  TX_REQFLITV  out  1  registered flit valid.
  TX_REQFLIT  out  154  registered flit.
  TX_REQLCRDV  in  1  one L-credit granted by receiver.
  RX_RSPFLITV  in  1  response flit valid.
  RX_RSPFLIT  in  73  response flit.
  crd_cnt  out  4  current credit count.
  txn_busy  out  NUM_TXN  TxnID in-use bitmap.
  link_state  out  2  0 STOP, 1 RUN, 2 RETURN.
  err_crd_ovf  out  1  sticky credit-overflow flag.
  err_unexp_comp  out  1  sticky unexpected-completion flag.

Function
REQ-003 FSM: STOP -> RUN when link_en=1; RUN -> RETURN when link_en=0; RETURN -> STOP when crd_cnt=0 and no return flit issued that cycle; encoding 3 unused, recovers to STOP.
REQ-004 Grant allowed only in RUN, with link_en=1, crd_cnt>0 and at least one txn_busy bit 0.
REQ-005 Arbitration round-robin; pointer starts at source 0, moves to other source after each grant; a lone valid source is granted regardless of pointer.
REQ-006 Grant in cycle N: req_ready[i]=1 in N; TX_REQFLITV=1 in N+1 with TX_REQFLIT = req_flit[i], except [37:26] = lowest free TxnID, zero-extended.
REQ-007 Granted TxnID marked busy at N edge; crd_cnt decremented at N edge.
REQ-008 TX_REQFLITV=0 in any cycle after a cycle without grant or return flit; TX_REQFLIT holds last value.
REQ-009 RETURN: each cycle with crd_cnt>0 emits ReqLCrdReturn flit next cycle (all bits 0, opcode [68:62]=0), decrementing crd_cnt; no source grants.
REQ-010 TX_REQLCRDV increments crd_cnt in all states; simultaneous LCRDV and consumption leaves crd_cnt unchanged.
REQ-011 LCRDV with crd_cnt=MAX_CRD and no consumption: count held, err_crd_ovf set.
REQ-012 RX_RSPFLITV with opcode [42:38]=5'h04 (Comp) and TxnID [37:26] < NUM_TXN and busy: bit cleared at that edge, reusable next cycle.
REQ-013 Comp with TxnID out of range or not busy: no state change, err_unexp_comp set; non-Comp opcodes ignored.
REQ-014 Completion freeing an ID and a grant in same cycle: grant uses only IDs free before that edge.
REQ-015 link_en toggling within RUN/RETURN only acts per REQ-003; RETURN never returns to RUN directly.

Reset
REQ-016 While rst=1 at posedge: state STOP, crd_cnt=0, txn_busy=0, RR pointer=0, TX_REQFLITV=0, TX_REQFLITPEND=0, TX_REQFLIT=0, both error flags 0; req_ready=0 during reset.
REQ-017 Reset mid-transaction discards outstanding TxnIDs and credits without emitting return flits.

Verification
REQ-018 Reset, link_en=1, 3 LCRDV pulses, both sources valid 4 cycles -> grants src0,src1,src0 with TxnIDs 0,1,2; crd_cnt 3->0; 4th cycle req_ready=0.
REQ-019 All 8 TxnIDs busy, credits 5 -> no grant; Comp TxnID 3 -> next cycle grant gets TxnID 3.
REQ-020 crd_cnt=2, LCRDV coincident with grant -> crd_cnt stays 2, flit issued.
REQ-021 crd_cnt=4, link_en->0 -> state RETURN, 4 consecutive all-zero flits with TX_REQFLITV=1, crd_cnt 0, then STOP.
REQ-022 16 LCRDV pulses from 0 -> crd_cnt=15, err_crd_ovf=1; Comp TxnID 9 -> err_unexp_comp=1, txn_busy unchanged.
REQ-023 rst asserted with 3 IDs busy and crd_cnt=2 in RUN -> all outputs at REQ-016 values next cycle, no return flits.
